register_file: RTL

//  Integer register file that serves as the responder for the writeback stage's

---
 rtl/register_file_pkg.sv | 23 ++
 rtl/register_file_if.sv | 22 ++
 rtl/register_file_read_port.sv | 46 ++++
 rtl/register_file.sv | 91 +++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared CPU-wide definitions for the integer register file: sizes, address
// and data types, the clear-sequencer state type and an address range helper.
package register_file_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;
  localparam int REG_ADDR_W     = $clog2(REGISTER_DEPTH);

  typedef logic [REG_ADDR_W-1:0]     reg_addr_t;
  typedef logic [REGISTER_WIDTH-1:0] reg_data_t;

  typedef enum logic {RF_INIT, RF_READY} rf_state_e;

  // Highest architectural register; the clear sequence stops after it.
  localparam reg_addr_t LAST_ADDR = reg_addr_t'(REGISTER_DEPTH - 1);

  // True when an address names a real register. Only matters when the depth
  // is not a power of two and the address field can exceed the array.
  function automatic logic addr_in_range(input reg_addr_t a);
    return int'(a) < REGISTER_DEPTH;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Simple memory-style port: enable + address + data.
// Handshake: there is no back-pressure. A transfer happens on every rising
// clock edge where enable is high. For a write port, data travels with the
// enable. For a read port, data is returned one cycle later and holds its
// value until the next enabled read.
interface MemoryInterface;
  import register_file_pkg::*;

  logic      enable;
  reg_addr_t address;
  reg_data_t data;

  // Responder side of a write port (the register file).
  modport write_in  (input enable, address, data);
  // Requester side of a write port (writeback stage).
  modport write_out (output enable, address, data);
  // Responder side of a read port (the register file).
  modport read_in   (input enable, address, output data);
  // Requester side of a read port (decode stage).
  modport read_out  (output enable, address, input data);

endinterface

// File: rtl/register_file_read_port.sv
// One registered read port: selects x0 / not-ready zero, same-cycle write
// bypass, or the array word, and holds the result when not enabled.
module register_file_read_port
  import register_file_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ready_i,
  input  logic            wr_en_i,
  input  reg_addr_t       wr_addr_i,
  input  reg_data_t       wr_data_i,
  input  reg_data_t       arr_data_i,
  MemoryInterface.read_in rd
);

  reg_data_t data_q;
  reg_data_t data_d;

  // Next read value: first matching rule wins; no enable keeps the old value.
  always_comb begin
    data_d = data_q;
    if (rd.enable) begin
      if (rd.address == '0 || !addr_in_range(rd.address)) begin
        data_d = '0;
      end else if (!ready_i) begin
        data_d = '0;
      end else if (wr_en_i && (wr_addr_i == rd.address)) begin
        data_d = wr_data_i;
      end else begin
        data_d = arr_data_i;
      end
    end
  end

  // Output register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd.data = data_q;

endmodule

// File: rtl/register_file.sv
// Integer register file: one write port, two registered read ports, x0 tied
// to zero. After reset a clear sequencer zeroes registers 1..DEPTH-1 so the
// array itself carries no reset and can map onto RAM.
module register_file
  import register_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  MemoryInterface.write_in registerport_write,
  MemoryInterface.read_in  registerport_rs1,
  MemoryInterface.read_in  registerport_rs2,
  output logic             init_done,
  output rf_state_e        dbg_state_o
);

  rf_state_e state_q;
  reg_addr_t clr_idx_q;
  logic      init_done_q;
  logic      wr_commit;
  reg_data_t rs1_arr;
  reg_data_t rs2_arr;

  reg_data_t mem [REGISTER_DEPTH];

  // A port write lands only once clearing is finished and never on x0.
  assign wr_commit = registerport_write.enable
                  && (state_q == RF_READY)
                  && (registerport_write.address != '0)
                  && addr_in_range(registerport_write.address);

  // Clear sequencer: walk index 1..DEPTH-1, then stay ready until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RF_INIT;
      clr_idx_q   <= reg_addr_t'(1);
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          if (clr_idx_q == LAST_ADDR) begin
            state_q     <= RF_READY;
            init_done_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + reg_addr_t'(1);
          end
        end
        default: begin
          state_q <= RF_READY;
        end
      endcase
    end
  end

  // Array write: the clear sequence owns the array until it completes.
  always_ff @(posedge clk) begin
    if (state_q == RF_INIT) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_commit) begin
      mem[registerport_write.address] <= registerport_write.data;
    end
  end

  assign rs1_arr = mem[registerport_rs1.address];
  assign rs2_arr = mem[registerport_rs2.address];

  register_file_read_port u_rs1 (
    .clk        (clk),
    .rst        (rst),
    .ready_i    (state_q == RF_READY),
    .wr_en_i    (registerport_write.enable),
    .wr_addr_i  (registerport_write.address),
    .wr_data_i  (registerport_write.data),
    .arr_data_i (rs1_arr),
    .rd         (registerport_rs1)
  );

  register_file_read_port u_rs2 (
    .clk        (clk),
    .rst        (rst),
    .ready_i    (state_q == RF_READY),
    .wr_en_i    (registerport_write.enable),
    .wr_addr_i  (registerport_write.address),
    .wr_data_i  (registerport_write.data),
    .arr_data_i (rs2_arr),
    .rd         (registerport_rs2)
  );

  assign init_done   = init_done_q;
  assign dbg_state_o = state_q;

endmodule
